// File: rtl/mon_sopc_button_debounce.sv
// Push-button conditioner ahead of the SOPC button PIO in_port.
// Each key is synchronized and debounced independently, and the block emits one-cycle press and release pulses.
module mon_sopc_button_debounce #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_clean,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0]     SYNC_RST = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [WIDTH-1:0]     lvl;
  logic [WIDTH-1:0]     accept_c;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];

  // Two-flop synchronizer; resets to the idle pin level so no false press is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign lvl = ACTIVE_LOW ? ~sync2 : sync2;

  // A bit is accepted when it still differs after a full stable run.
  always_comb begin
    accept_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      accept_c[i] = (lvl[i] != btn_clean[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Stability counters: any agreement with the current level restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if ((lvl[i] == btn_clean[i]) || accept_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Clean level and edge pulses update together on the accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_clean <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
    end else begin
      btn_clean <= btn_clean ^ accept_c;
      btn_rise  <= accept_c & lvl;
      btn_fall  <= accept_c & ~lvl;
    end
  end

endmodule

// File: doc/mon_sopc_button_debounce.md
Name:
mon_sopc_button_debounce

Overview:
- Conditions raw push-button pins before they reach the 2-bit Avalon PIO input port (in_port) of the SOPC button peripheral.
- Synchronizes each asynchronous key to clk, rejects contact bounce with a per-bit stability counter, and outputs a clean active-high level per button.
- Also produces one-cycle press/release pulses for optional edge-capture logic.
- Sits between the board key pins and the PIO in_port.

Parameters:
- WIDTH, 2, number of buttons; matches the PIO in_port width.
- CNT_WIDTH, 20, width of each per-bit stability counter; must satisfy 2^CNT_WIDTH >= DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz); legal range >= 2.
- ACTIVE_LOW, 1, 1 = board keys read 0 when pressed (inverted after synchronization); 0 = keys read 1 when pressed.

Ports:
- clk, input, 1, system clock; single clock domain.
- reset_n, input, 1, asynchronous active-low reset.
- btn_raw, input, WIDTH, raw key pins; asynchronous to clk.
- btn_clean, output, WIDTH, debounced level, 1 = pressed; drives PIO in_port.
- btn_rise, output, WIDTH, one-cycle pulse per bit on accepted press (btn_clean 0->1).
- btn_fall, output, WIDTH, one-cycle pulse per bit on accepted release (btn_clean 1->0).

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-low on reset_n.
  - All flops use posedge clk or negedge reset_n.
- Reset values:
  - Both synchronizer stages = inactive pin level (all 1 if ACTIVE_LOW = 1, else all 0).
  - Counters = 0.
  - btn_clean = 0, btn_rise = 0, btn_fall = 0.
- Synchronizer:
  - Two flops per bit: sync1 <= btn_raw, then sync2 <= sync1.
  - lvl = ACTIVE_LOW ? ~sync2 : sync2.
  - lvl is the only signal used downstream.
- Debounce, per bit i, fully independent of the other bits:
  - lvl[i] == btn_clean[i]: cnt[i] <= 0 (glitch rejected, count restarts).
  - lvl[i] != btn_clean[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - lvl[i] != btn_clean[i] and cnt[i] == DEBOUNCE_CYCLES-1: btn_clean[i] <= lvl[i] and cnt[i] <= 0.
- Edge pulses:
  - btn_rise[i] and btn_fall[i] are registered.
  - Each is high for exactly the one cycle following the edge at which btn_clean[i] changes (aligned with the new btn_clean value).
  - Both are 0 in every other cycle; rise and fall are never high together on one bit.
- Latency:
  - Edge 0 is the first clock edge that samples a new raw level.
  - If the new level holds continuously, btn_clean changes after edge DEBOUNCE_CYCLES+1.
- Boundaries:
  - Any reversion of lvl before the count completes clears cnt. No partial credit, no hysteresis carry-over.
  - Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - Simultaneous changes on several bits are debounced in parallel; their pulses may coincide.
  - reset_n asserted mid-count: immediate return to reset values.
  - After reset release, a key already pressed is accepted after DEBOUNCE_CYCLES+2 edges, with a btn_rise pulse.
  - No combinational path from btn_raw to any output.

Test Plan:
- Reset: hold reset_n = 0 with btn_raw = 2'b11 (ACTIVE_LOW = 1, DEBOUNCE_CYCLES = 8) -> btn_clean = 00, btn_rise = btn_fall = 00; after release, outputs stay 00 indefinitely.
- Clean press: btn_raw[0] 1->0, then held -> btn_clean[0] = 1 after edge 9, btn_rise[0] = 1 for exactly one cycle, btn_clean[1] stays 0.
- Bounce reject: btn_raw[1] toggles 0/1 with high/low runs of 3, 5 and 7 cycles, then settles at 0 -> no change until 8 consecutive stable sync cycles, then exactly one btn_rise[1] pulse.
- Release: from btn_clean = 11, btn_raw = 2'b11 held -> both bits drop together after edge 9, btn_fall = 11 for one cycle, no btn_rise.
- Reset mid-count: press btn_raw[0], assert reset_n at cycle 5 for 2 cycles, keep pressed -> btn_clean[0] = 0 during reset; after release, it rises after a full 10 edges, with one pulse.
- Glitch length D-1: a 7-cycle low pulse on btn_raw[0] -> btn_clean and pulses remain 0; cnt returns to 0.
